// File: rtl/conv_pkg.sv
// Shared types and width helpers for the 1-D convolution compute block.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_WRITE   = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2,
    ST_DONE    = 2'd3
  } conv_state_e;

  // Sum of FILTER_N full-width products needs LG_FILTER_N guard bits.
  function automatic int conv_out_w(input int in_w, input int lg_filter_n);
    return (in_w + in_w) + lg_filter_n;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate datapath: aligns the 1-cycle memory latency and
// accumulates full-precision signed products.
module conv_mac
  import conv_pkg::*;
#(
  parameter int IN_W        = 16,
  parameter int LG_FILTER_N = 3,
  localparam int OUT_W      = conv_out_w(IN_W, LG_FILTER_N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue,
  input  logic                    clear,
  input  logic signed [IN_W-1:0]  data_x,
  input  logic signed [IN_W-1:0]  data_f,
  output logic signed [OUT_W-1:0] acc
);

  localparam int PROD_W = IN_W + IN_W;

  logic                     data_valid_r;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [OUT_W-1:0]  prod_ext_s;
  logic signed [OUT_W-1:0]  acc_r;

  // Read data belongs to the address issued one cycle earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid_r <= 1'b0;
    end else begin
      data_valid_r <= issue;
    end
  end

  // Sign-extended operands give the exact signed product modulo 2^PROD_W.
  always_comb begin
    prod_s     = $signed({{IN_W{data_x[IN_W-1]}}, data_x} * {{IN_W{data_f[IN_W-1]}}, data_f});
    prod_ext_s = {{(OUT_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end

  // Accumulator; clear takes priority over accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (data_valid_r) begin
      acc_r <= acc_r + prod_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/conv_compute_ctrl.sv
// Convolution controller: load/compute/output FSM, j/k counters and
// registered memory read addresses around the conv_mac datapath.
module conv_compute_ctrl
  import conv_pkg::*;
#(
  parameter int X_N         = 16,
  parameter int LG_X_N      = 4,
  parameter int FILTER_N    = 8,
  parameter int LG_FILTER_N = 3,
  parameter int IN_W        = 16,
  localparam int OUT_W      = conv_out_w(IN_W, LG_FILTER_N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done_x,
  input  logic                    done_f,
  output logic                    mem_wr_state,
  output logic                    mem_wr_done,
  output logic [LG_X_N-1:0]       addr_x,
  output logic [LG_FILTER_N-1:0]  addr_f,
  input  logic signed [IN_W-1:0]  data_x,
  input  logic signed [IN_W-1:0]  data_f,
  output logic signed [OUT_W-1:0] m_data_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);

  localparam int                   J_LAST_I = X_N - FILTER_N;
  localparam logic [LG_X_N-1:0]    J_LAST   = J_LAST_I[LG_X_N-1:0];
  localparam logic [LG_X_N-1:0]    J_ONE    = {{(LG_X_N-1){1'b0}}, 1'b1};
  localparam logic [LG_FILTER_N:0] K_LAST   = FILTER_N[LG_FILTER_N:0];
  localparam logic [LG_FILTER_N:0] K_ONE    = {{LG_FILTER_N{1'b0}}, 1'b1};

  conv_state_e            state_r, next_state_s;
  logic [LG_X_N-1:0]      j_r, j_next_s;
  logic [LG_FILTER_N:0]   k_r, k_next_s;
  logic [LG_X_N-1:0]      addr_x_r, addr_x_next_s;
  logic [LG_FILTER_N-1:0] addr_f_r, addr_f_next_s;
  logic                   mem_wr_state_r, mem_wr_state_next_s;
  logic                   mem_wr_done_r, mem_wr_done_next_s;
  logic                   m_valid_r, m_valid_next_s;
  logic                   issue_s, clear_s;
  logic signed [OUT_W-1:0] acc_s;

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_WRITE;
      j_r            <= '0;
      k_r            <= '0;
      addr_x_r       <= '0;
      addr_f_r       <= '0;
      mem_wr_state_r <= 1'b1;
      mem_wr_done_r  <= 1'b0;
      m_valid_r      <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      j_r            <= j_next_s;
      k_r            <= k_next_s;
      addr_x_r       <= addr_x_next_s;
      addr_f_r       <= addr_f_next_s;
      mem_wr_state_r <= mem_wr_state_next_s;
      mem_wr_done_r  <= mem_wr_done_next_s;
      m_valid_r      <= m_valid_next_s;
    end
  end

  // Next state and counter values; k counts 0..FILTER_N inside COMPUTE.
  always_comb begin
    next_state_s = state_r;
    j_next_s     = j_r;
    k_next_s     = '0;
    case (state_r)
      ST_WRITE: begin
        j_next_s = '0;
        if (done_x && done_f) begin
          next_state_s = ST_COMPUTE;
        end else begin
          next_state_s = ST_WRITE;
        end
      end
      ST_COMPUTE: begin
        if (k_r == K_LAST) begin
          next_state_s = ST_OUTPUT;
          k_next_s     = '0;
        end else begin
          next_state_s = ST_COMPUTE;
          k_next_s     = k_r + K_ONE;
        end
      end
      ST_OUTPUT: begin
        if (!m_ready_y) begin
          next_state_s = ST_OUTPUT;
        end else if (j_r == J_LAST) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_COMPUTE;
          j_next_s     = j_r + J_ONE;
        end
      end
      ST_DONE: begin
        next_state_s = ST_WRITE;
        j_next_s     = '0;
      end
      default: begin
        next_state_s = ST_WRITE;
        j_next_s     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the block registered.
  always_comb begin
    issue_s             = (state_r == ST_COMPUTE) && (k_r < K_LAST);
    clear_s             = (state_r == ST_COMPUTE) && (k_r == '0);
    mem_wr_state_next_s = (next_state_s == ST_WRITE);
    mem_wr_done_next_s  = (next_state_s == ST_DONE);
    m_valid_next_s      = (next_state_s == ST_OUTPUT);
    if ((next_state_s == ST_COMPUTE) && (k_next_s < K_LAST)) begin
      addr_x_next_s = j_next_s + LG_X_N'(k_next_s);
      addr_f_next_s = k_next_s[LG_FILTER_N-1:0];
    end else begin
      addr_x_next_s = '0;
      addr_f_next_s = '0;
    end
  end

  conv_mac #(
    .IN_W        (IN_W),
    .LG_FILTER_N (LG_FILTER_N)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .issue  (issue_s),
    .clear  (clear_s),
    .data_x (data_x),
    .data_f (data_f),
    .acc    (acc_s)
  );

  assign mem_wr_state = mem_wr_state_r;
  assign mem_wr_done  = mem_wr_done_r;
  assign addr_x       = addr_x_r;
  assign addr_f       = addr_f_r;
  assign m_valid_y    = m_valid_r;
  assign m_data_y     = acc_s;

endmodule

// File: tb/tb_conv_compute_ctrl.sv
// Scoreboard bench for conv_compute_ctrl: a reference convolution fills an
// expectation queue, a negedge monitor pops and compares on each handshake.
module tb_conv_compute_ctrl;

  localparam int X_N = 16, LG_X_N = 4, FILTER_N = 8, LG_FILTER_N = 3, IN_W = 16;
  localparam int OUT_W = 35;
  localparam int NY = X_N - FILTER_N + 1;

  logic clk = 1'b0, reset = 1'b1, done_x = 1'b0, done_f = 1'b0, m_ready_y = 1'b1;
  logic mem_wr_state, mem_wr_done, m_valid_y;
  logic [LG_X_N-1:0] addr_x;
  logic [LG_FILTER_N-1:0] addr_f;
  logic signed [IN_W-1:0] data_x, data_f;
  logic signed [OUT_W-1:0] m_data_y;
  logic signed [IN_W-1:0] xm [X_N];
  logic signed [IN_W-1:0] fm [FILTER_N];

  longint exp_q[$];
  int errors = 0, checks = 0;
  int hs_cnt = 0, done_cnt = 0, cyc = 0, entry_cyc = 0;
  logic prev_ws = 1'b1, prev_hs = 1'b0, prev_valid = 1'b0;
  logic signed [OUT_W-1:0] prev_data = '0;

  always #5 clk = ~clk;

  conv_compute_ctrl #(
    .X_N(X_N), .LG_X_N(LG_X_N), .FILTER_N(FILTER_N), .LG_FILTER_N(LG_FILTER_N), .IN_W(IN_W)
  ) dut (
    .clk(clk), .reset(reset), .done_x(done_x), .done_f(done_f),
    .mem_wr_state(mem_wr_state), .mem_wr_done(mem_wr_done),
    .addr_x(addr_x), .addr_f(addr_f), .data_x(data_x), .data_f(data_f),
    .m_data_y(m_data_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
  );

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    data_x <= xm[addr_x];
    data_f <= fm[addr_f];
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: latency, hold-under-backpressure and scoreboard comparisons.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if ((prev_ws && !mem_wr_state) || prev_hs) entry_cyc = cyc;
      if (m_valid_y && !prev_valid) check("first_valid_latency", cyc - entry_cyc, FILTER_N + 1);
      if (prev_valid && !prev_hs) begin
        check("hold_valid", m_valid_y, 1);
        check("hold_data", m_data_y, prev_data);
      end
      if (m_valid_y) begin
        check("addr_x_in_output", addr_x, 0);
        check("addr_f_in_output", addr_f, 0);
        check("wr_state_in_output", mem_wr_state, 0);
      end
      if (mem_wr_done) done_cnt++;
      if (m_valid_y && m_ready_y) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check("y_value", m_data_y, exp_q.pop_front());
      end
    end
    prev_ws    = mem_wr_state;
    prev_hs    = !reset && m_valid_y && m_ready_y;
    prev_valid = m_valid_y;
    prev_data  = m_data_y;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: direct sum of products over the current memory contents.
  task automatic push_model();
    for (int j = 0; j < NY; j++) begin
      longint s = 0;
      for (int k = 0; k < FILTER_N; k++) s += longint'(xm[j + k]) * longint'(fm[k]);
      exp_q.push_back(s);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < X_N; i++) xm[i] = IN_W'($urandom);
    for (int i = 0; i < FILTER_N; i++) fm[i] = IN_W'($urandom);
  endtask

  task automatic start_frame();
    repeat ($urandom_range(0, 3)) tick();
    done_x = 1'b1;
    done_f = 1'b1;
    tick();
    done_x = 1'b0;
    done_f = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles on the first result
  task automatic run_frame(input int mode);
    int d0, h0, hold, n;
    d0 = done_cnt; h0 = hs_cnt; hold = 0; n = 0;
    push_model();
    start_frame();
    while (done_cnt == d0 && n < 3000) begin
      case (mode)
        0: m_ready_y = 1'b1;
        1: m_ready_y = ($urandom_range(0, 1) == 1);
        default: begin
          if (m_valid_y && hold < 5) begin
            m_ready_y = 1'b0;
            hold++;
          end else begin
            m_ready_y = 1'b1;
          end
        end
      endcase
      tick();
      n++;
    end
    m_ready_y = 1'b1;
    check("done_pulse_count", done_cnt - d0, 1);
    check("output_count", hs_cnt - h0, NY);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0, h0, n;
    for (int i = 0; i < X_N; i++) xm[i] = '0;
    for (int i = 0; i < FILTER_N; i++) fm[i] = '0;

    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("reset_valid", m_valid_y, 0);
    check("reset_wr_done", mem_wr_done, 0);
    check("reset_wr_state", mem_wr_state, 1);
    check("reset_addr_x", addr_x, 0);
    check("reset_addr_f", addr_f, 0);
    check("reset_data", m_data_y, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < X_N; i++) xm[i] = IN_W'(i);
    for (int i = 0; i < FILTER_N; i++) fm[i] = 16'sd1;
    run_frame(0);
    run_frame(2);

    for (int i = 0; i < X_N; i++) xm[i] = 16'sh8000;
    for (int i = 0; i < FILTER_N; i++) fm[i] = 16'sh8000;
    run_frame(1);

    repeat (3) begin
      fill_random();
      run_frame(1);
    end

    // Abort a frame while computing j=3.
    fill_random();
    d0 = done_cnt; h0 = hs_cnt; n = 0;
    push_model();
    start_frame();
    m_ready_y = 1'b1;
    while (hs_cnt - h0 < 3 && n < 500) begin
      tick();
      n++;
    end
    check("reach_j3", hs_cnt - h0, 3);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_wr_state", mem_wr_state, 1);
    check("abort_valid", m_valid_y, 0);
    check("abort_addr_x", addr_x, 0);
    repeat (15) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_output", hs_cnt - h0, 3);
    check("abort_in_write", mem_wr_state, 1);
    exp_q.delete();
    fill_random();
    run_frame(0);

    // Loader not finished: the block must wait in WRITE.
    done_x = 1'b1;
    done_f = 1'b0;
    repeat (10) begin
      tick();
      check("wait_wr_state", mem_wr_state, 1);
      check("wait_no_valid", m_valid_y, 0);
    end
    done_x = 1'b0;
    fill_random();
    run_frame(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_compute_ctrl.md
CONV_COMPUTE_CTRL -- requirements
Module: conv_compute_ctrl

Interface
REQ-001 SHALL have parameter X_N, default 16, meaning input-vector length (X memory depth).
REQ-002 SHALL have parameter LG_X_N, default 4, meaning log2(X_N).
REQ-003 SHALL have parameter FILTER_N, default 8, meaning filter length (F memory depth); FILTER_N <= X_N.
REQ-004 SHALL have parameter LG_FILTER_N, default 3, meaning log2(FILTER_N).
REQ-005 SHALL have parameter IN_W, default 16, meaning signed sample width of X and F.
REQ-006 SHALL have derived localparam OUT_W = 2*IN_W + LG_FILTER_N (35), meaning output width.
REQ-007 SHALL use a single clock and a synchronous, active-high reset: clk, in, 1, rising-edge clock; reset, in, 1, synchronous active-high reset.
REQ-008 SHALL have port done_x, in, 1, X vector fully loaded.
REQ-009 SHALL have port done_f, in, 1, F vector fully loaded.
REQ-010 SHALL have port mem_wr_state, out, 1, load phase active; also selects writer addresses at the external memory address mux.
REQ-011 SHALL have port mem_wr_done, out, 1, one-cycle pulse at the end of a frame; loaders wrap their addresses to 0.
REQ-012 SHALL have port addr_x, out, LG_X_N, X memory read address.
REQ-013 SHALL have port addr_f, out, LG_FILTER_N, F memory read address.
REQ-014 SHALL have port data_x, in, IN_W signed, X read data, 1-cycle read latency.
REQ-015 SHALL have port data_f, in, IN_W signed, F read data, 1-cycle read latency.
REQ-016 SHALL have port m_data_y, out, OUT_W signed, convolution result.
REQ-017 SHALL have port m_valid_y, out, 1, m_data_y valid.
REQ-018 SHALL have port m_ready_y, in, 1, downstream accepts the result.

Function
REQ-019 SHALL implement the FSM states WRITE, COMPUTE, OUTPUT and DONE.
REQ-020 In WRITE, SHALL drive mem_wr_state=1 and move to COMPUTE in the cycle after done_x & done_f are both sampled high.
REQ-021 SHALL compute y[j] = sum over k=0..FILTER_N-1 of x[j+k]*f[k], for j = 0..X_N-FILTER_N (9 outputs at defaults).
REQ-022 In COMPUTE, SHALL issue addr_x=j+k and addr_f=k for k=0..FILTER_N-1 on consecutive cycles, one k per cycle.
REQ-023 SHALL accumulate data_x*data_f one cycle after the matching address issue, using full-width signed arithmetic with no saturation or truncation.
REQ-024 SHALL clear the accumulator on every entry to COMPUTE.
REQ-025 SHALL spend exactly FILTER_N+1 cycles in COMPUTE, then move to OUTPUT.
REQ-026 In OUTPUT, SHALL drive m_valid_y=1 with m_data_y equal to the accumulator, and hold both stable until m_ready_y=1.
REQ-027 On an OUTPUT handshake with j < X_N-FILTER_N, SHALL increment j and return to COMPUTE.
REQ-028 On an OUTPUT handshake with j = X_N-FILTER_N, SHALL move to DONE.
REQ-029 SHALL stay in DONE for 1 cycle with mem_wr_done=1, then return to WRITE with j=0.
REQ-030 SHALL hold m_valid_y=0 in every state other than OUTPUT.
REQ-031 SHALL hold mem_wr_state=0 in every state other than WRITE.
REQ-032 SHALL ignore done_x and done_f outside WRITE.
REQ-033 SHALL ignore m_ready_y outside OUTPUT.
REQ-034 SHALL drive addr_x and addr_f to 0 outside COMPUTE.
REQ-035 SHALL count j with an LG_X_N-bit counter and k with an (LG_FILTER_N+1)-bit counter; neither counter shall ever wrap.

Reset
REQ-036 On reset, SHALL enter WRITE with mem_wr_state=1.
REQ-037 On reset, SHALL force mem_wr_done=0, m_valid_y=0, m_data_y=0, addr_x=0, addr_f=0, and clear j, k and the accumulator.
REQ-038 A reset asserted in any state, including mid-COMPUTE or mid-OUTPUT, SHALL abort the frame with no mem_wr_done pulse and no further m_valid_y.

Structure
REQ-039 SHALL define the state enum type and the OUT_W width function in shared package conv_pkg.
REQ-040 SHALL place the multiply-accumulate datapath (1-cycle data-valid register, signed product, accumulator with clear) in one sub-module, conv_mac.
REQ-041 SHALL keep the FSM, counters and address generation in conv_compute_ctrl.

Verification
REQ-042 Reset check: assert reset for 2 cycles -> m_valid_y=0, mem_wr_done=0, mem_wr_state=1, addresses=0.
REQ-043 Basic frame: x[i]=i, f[k]=1, done_x=done_f=1, m_ready_y=1 -> y = 28, 36, 44, ..., 92 (9 values); each first m_valid_y appears FILTER_N+1 cycles after entry to COMPUTE; one mem_wr_done pulse follows.
REQ-044 Backpressure: hold m_ready_y=0 for 5 cycles at y[0] -> m_valid_y and m_data_y stay stable for all 5 cycles, and addr_x/addr_f stay 0.
REQ-045 Extreme values: x = f = -32768 everywhere -> every y = 8*2^30 = 8589934592 with no overflow in 35 bits.
REQ-046 Mid-frame reset: reset at COMPUTE of j=3 -> return to WRITE next cycle with no mem_wr_done; a following frame produces correct results.
REQ-047 Frame loopback: after mem_wr_done, keep done_f=0 for 10 cycles -> block waits in WRITE; then assert done_x & done_f -> second frame computes correctly.
